// File: rtl/dm_port_arbiter_pkg.sv
// rtl/dm_port_arbiter_pkg.sv - shared size codes, FSM states and owner tags for the data-memory port arbiter
package dm_pkg;

  localparam logic [1:0] B  = 2'b00;
  localparam logic [1:0] HW = 2'b01;
  localparam logic [1:0] W  = 2'b10;
  localparam logic [1:0] DW = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } dm_arb_state_t;

  typedef enum logic {
    OWN_P = 1'b0,
    OWN_S = 1'b1
  } dm_owner_t;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// rtl/dm_port_arbiter_if.sv - requester-side and memory-side bundles of the data-memory port arbiter
interface dm_req_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;

  modport master (output req, we, size, addr, wdata, input ready, rvalid, rdata, err);
  modport slave  (input req, we, size, addr, wdata, output ready, rvalid, rdata, err);
endinterface

interface dm_mem_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dm_port_arbiter_be_gen.sv
// rtl/dm_port_arbiter_be_gen.sv - alignment check, byte enables and lane-replicated store data
module dm_be_gen
  import dm_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [2:0]  i_addr,
  input  logic [63:0] i_wdata,
  output logic        o_misaligned,
  output logic [7:0]  o_be,
  output logic [63:0] o_wdata
);

  always_comb begin
    o_misaligned = 1'b0;
    o_be         = 8'hFF;
    o_wdata      = i_wdata;
    case (i_size)
      B: begin
        o_be    = 8'h01 << i_addr;
        o_wdata = {8{i_wdata[7:0]}};
      end
      HW: begin
        o_misaligned = i_addr[0];
        o_be         = 8'h03 << i_addr;
        o_wdata      = {4{i_wdata[15:0]}};
      end
      W: begin
        o_misaligned = |i_addr[1:0];
        o_be         = 8'h0F << i_addr;
        o_wdata      = {2{i_wdata[31:0]}};
      end
      default: begin
        o_misaligned = |i_addr;
        o_be         = 8'hFF;
        o_wdata      = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - single-outstanding arbiter for the 64-bit data-memory port (MEM stage vs secondary)
// Defining DM_ARB_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module dm_port_arbiter
  import dm_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  dm_req_if.slave    p,
  dm_req_if.slave    s,
  dm_mem_if.master   dm
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  dm_arb_state_t r_state;
  dm_arb_state_t w_state_nxt;
  dm_owner_t     r_owner;
  logic [SW-1:0] r_starve_cnt;
  logic          r_we;
  logic [63:0]   r_addr;
  logic [7:0]    r_be;
  logic [63:0]   r_wdata;
  logic [63:0]   r_rdata;
  logic          r_err;

  logic          w_starved;
  logic          w_grant_p;
  logic          w_grant_s;
  logic          w_accept;
  logic          w_we;
  logic [1:0]    w_size;
  logic [63:0]   w_addr;
  logic [63:0]   w_wdata;
  logic          w_misaligned;
  logic [7:0]    w_be;
  logic [63:0]   w_lane_wdata;
  logic          w_timeout;
  logic          w_p_rvalid;
  logic          w_s_rvalid;

  // Primary wins unless the secondary has waited out STARVE_LIMIT primary grants.
  assign w_starved = (r_starve_cnt == SW'(STARVE_LIMIT));
  assign w_grant_s = (r_state == ST_IDLE) && s.req && (!p.req || w_starved);
  assign w_grant_p = (r_state == ST_IDLE) && p.req && !w_grant_s;
  assign w_accept  = w_grant_p || w_grant_s;

  assign w_we    = w_grant_s ? s.we    : p.we;
  assign w_size  = w_grant_s ? s.size  : p.size;
  assign w_addr  = w_grant_s ? s.addr  : p.addr;
  assign w_wdata = w_grant_s ? s.wdata : p.wdata;

  dm_be_gen u_be_gen (
    .i_size       (w_size),
    .i_addr       (w_addr[2:0]),
    .i_wdata      (w_wdata),
    .o_misaligned (w_misaligned),
    .o_be         (w_be),
    .o_wdata      (w_lane_wdata)
  );

`ifdef DM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_WAIT) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = w_misaligned ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (dm.gnt) w_state_nxt = ST_WAIT;
      ST_WAIT:  if (dm.rvalid || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_owner      <= OWN_P;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      if (!s.req || w_grant_s) begin
        r_starve_cnt <= '0;
      end else if (w_grant_p && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      // A misaligned request latches err here and goes straight to RESP.
      if (w_accept) begin
        r_owner <= w_grant_s ? OWN_S : OWN_P;
        r_we    <= w_we;
        r_addr  <= {w_addr[63:3], 3'b000};
        r_be    <= w_be;
        r_wdata <= w_lane_wdata;
        r_rdata <= '0;
        r_err   <= w_misaligned;
      end

      if (r_state == ST_WAIT) begin
        if (dm.rvalid) begin
          r_rdata <= dm.rdata;
          r_err   <= dm.err;
        end else if (w_timeout) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign w_p_rvalid = (r_state == ST_RESP) && (r_owner == OWN_P);
  assign w_s_rvalid = (r_state == ST_RESP) && (r_owner == OWN_S);

  assign p.ready  = w_grant_p;
  assign p.rvalid = w_p_rvalid;
  assign p.rdata  = w_p_rvalid ? r_rdata : '0;
  assign p.err    = w_p_rvalid && r_err;

  assign s.ready  = w_grant_s;
  assign s.rvalid = w_s_rvalid;
  assign s.rdata  = w_s_rvalid ? r_rdata : '0;
  assign s.err    = w_s_rvalid && r_err;

  assign dm.req   = (r_state == ST_ISSUE);
  assign dm.we    = r_we;
  assign dm.addr  = r_addr;
  assign dm.be    = r_be;
  assign dm.wdata = r_wdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - directed self-checking bench for dm_port_arbiter (timeout step needs DM_ARB_TIMEOUT_EN)
module tb_dm_port_arbiter;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dm_req_if p_if ();
  dm_req_if s_if ();
  dm_mem_if dm_if ();

  dm_port_arbiter #(
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .p   (p_if),
    .s   (s_if),
    .dm  (dm_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    string exp_seq;
    logic  exp_p;

    rst = 1'b1;
    p_if.req = 0; p_if.we = 0; p_if.size = B; p_if.addr = '0; p_if.wdata = '0;
    s_if.req = 0; s_if.we = 0; s_if.size = B; s_if.addr = '0; s_if.wdata = '0;
    dm_if.gnt = 0; dm_if.rvalid = 0; dm_if.rdata = '0; dm_if.err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_req", dm_if.req, 0);
    chk("rst_dm_addr", dm_if.addr, 0);
    chk("rst_dm_be", dm_if.be, 0);
    chk("rst_p_rvalid", p_if.rvalid, 0);
    chk("rst_s_rvalid", s_if.rvalid, 0);
    chk("rst_p_rdata", p_if.rdata, 0);
    rst = 1'b0;

    // Primary DW load at 0x1000, immediate grant, data one cycle later.
    p_if.req = 1; p_if.we = 0; p_if.size = DW; p_if.addr = 64'h1000;
    #1;
    chk("t1_p_ready", p_if.ready, 1);
    chk("t1_s_ready", s_if.ready, 0);
    step();
    p_if.req = 0;
    chk("t1_dm_req", dm_if.req, 1);
    chk("t1_dm_addr", dm_if.addr, 64'h1000);
    chk("t1_dm_be", dm_if.be, 8'hFF);
    chk("t1_dm_we", dm_if.we, 0);
    dm_if.gnt = 1;
    step();
    dm_if.gnt = 0;
    chk("t1_wait_dm_req", dm_if.req, 0);
    chk("t1_wait_p_rvalid", p_if.rvalid, 0);
    dm_if.rvalid = 1; dm_if.rdata = 64'hDEADBEEF_CAFEF00D;
    step();
    dm_if.rvalid = 0; dm_if.rdata = '0;
    chk("t1_p_rvalid", p_if.rvalid, 1);
    chk("t1_p_rdata", p_if.rdata, 64'hDEADBEEF_CAFEF00D);
    chk("t1_p_err", p_if.err, 0);
    chk("t1_s_rvalid", s_if.rvalid, 0);
    step();
    chk("t1_p_rvalid_drop", p_if.rvalid, 0);

    // Secondary B store at 0x2005, bus error on the response.
    s_if.req = 1; s_if.we = 1; s_if.size = B; s_if.addr = 64'h2005; s_if.wdata = 64'hAB;
    #1;
    chk("t2_s_ready", s_if.ready, 1);
    chk("t2_p_ready", p_if.ready, 0);
    step();
    s_if.req = 0;
    chk("t2_dm_req", dm_if.req, 1);
    chk("t2_dm_addr", dm_if.addr, 64'h2000);
    chk("t2_dm_be", dm_if.be, 8'h20);
    chk("t2_dm_wdata", dm_if.wdata, 64'hABABABABABABABAB);
    chk("t2_dm_we", dm_if.we, 1);
    dm_if.gnt = 1;
    step();
    dm_if.gnt = 0;
    dm_if.rvalid = 1; dm_if.rdata = 64'h55; dm_if.err = 1;
    step();
    dm_if.rvalid = 0; dm_if.rdata = '0; dm_if.err = 0;
    chk("t2_s_rvalid", s_if.rvalid, 1);
    chk("t2_s_rdata", s_if.rdata, 64'h55);
    chk("t2_s_err", s_if.err, 1);
    chk("t2_p_rvalid", p_if.rvalid, 0);
    step();

    // Primary W load at 0x3002 is misaligned: response at cycle 1, no memory request.
    p_if.req = 1; p_if.we = 0; p_if.size = W; p_if.addr = 64'h3002;
    #1;
    chk("t3_p_ready", p_if.ready, 1);
    step();
    p_if.req = 0;
    chk("t3_p_rvalid", p_if.rvalid, 1);
    chk("t3_p_err", p_if.err, 1);
    chk("t3_p_rdata", p_if.rdata, 0);
    chk("t3_dm_req", dm_if.req, 0);
    step();
    chk("t3_dm_req_after", dm_if.req, 0);
    chk("t3_p_rvalid_drop", p_if.rvalid, 0);

    // Both ports requesting continuously: every fifth grant goes to the secondary.
    exp_seq = "PPPPSPPPPS";
    p_if.req = 1; p_if.we = 0; p_if.size = DW; p_if.addr = 64'h100;
    s_if.req = 1; s_if.we = 0; s_if.size = DW; s_if.addr = 64'h200;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_p = (exp_seq[i] == "P");
      chk($sformatf("t4_grant%0d_p", i), p_if.ready, exp_p);
      chk($sformatf("t4_grant%0d_s", i), s_if.ready, !exp_p);
      step();
      dm_if.gnt = 1;
      step();
      dm_if.gnt = 0; dm_if.rvalid = 1; dm_if.rdata = 64'(i);
      step();
      dm_if.rvalid = 0;
      chk($sformatf("t4_resp%0d_p", i), p_if.rvalid, exp_p);
      chk($sformatf("t4_resp%0d_s", i), s_if.rvalid, !exp_p);
      step();
    end
    p_if.req = 0; s_if.req = 0;
    #1;

    // Grant withheld for 5 cycles, then reset while waiting for the response.
    p_if.req = 1; p_if.we = 1; p_if.size = HW; p_if.addr = 64'h4006; p_if.wdata = 64'h1234;
    #1;
    chk("t5_p_ready", p_if.ready, 1);
    step();
    p_if.req = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_hold%0d_req", i), dm_if.req, 1);
      chk($sformatf("t5_hold%0d_addr", i), dm_if.addr, 64'h4000);
      chk($sformatf("t5_hold%0d_be", i), dm_if.be, 8'hC0);
      chk($sformatf("t5_hold%0d_wdata", i), dm_if.wdata, 64'h1234123412341234);
      step();
    end
    dm_if.gnt = 1;
    step();
    dm_if.gnt = 0;
    chk("t5_wait_dm_req", dm_if.req, 0);
    rst = 1'b1;
    #1;
    chk("t5_rst_dm_we", dm_if.we, 0);
    chk("t5_rst_dm_addr", dm_if.addr, 0);
    chk("t5_rst_dm_be", dm_if.be, 0);
    chk("t5_rst_dm_wdata", dm_if.wdata, 0);
    chk("t5_rst_p_rvalid", p_if.rvalid, 0);
    step();
    rst = 1'b0;
    dm_if.rvalid = 1; dm_if.rdata = 64'h77;
    step();
    dm_if.rvalid = 0; dm_if.rdata = '0;
    chk("t5_stray_p_rvalid", p_if.rvalid, 0);
    chk("t5_stray_s_rvalid", s_if.rvalid, 0);
    chk("t5_stray_dm_req", dm_if.req, 0);
    step();
    chk("t5_stray_p_rvalid2", p_if.rvalid, 0);
    p_if.req = 1; p_if.size = B; p_if.addr = 64'h10;
    #1;
    chk("t5_idle_ready", p_if.ready, 1);
    p_if.req = 0;
    step();
    chk("t5_no_accept", dm_if.req, 0);

`ifdef DM_ARB_TIMEOUT_EN
    // No response at all: watchdog returns err after 8 WAIT cycles.
    p_if.req = 1; p_if.we = 0; p_if.size = DW; p_if.addr = 64'h5000;
    #1;
    chk("t6_p_ready", p_if.ready, 1);
    step();
    p_if.req = 0;
    dm_if.gnt = 1;
    step();
    dm_if.gnt = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("t6_wait%0d_rvalid", i), p_if.rvalid, 0);
    end
    step();
    chk("t6_p_rvalid", p_if.rvalid, 1);
    chk("t6_p_err", p_if.err, 1);
    chk("t6_p_rdata", p_if.rdata, 0);
    dm_if.rvalid = 1; dm_if.rdata = 64'h99;
    step();
    dm_if.rvalid = 0;
    chk("t6_late_rvalid", p_if.rvalid, 0);
    step();
    chk("t6_late_rvalid2", p_if.rvalid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
